// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command codes, arbiter state encoding and default refresh interval.
package sdram_pkg;
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_AREF      = 4'b0001;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_MREG      = 4'b0000;
   localparam int CNT_REF_DEF = 750;
   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      ARBIT = 5'b00010,
      AREF  = 5'b00100,
      WRITE = 5'b01000,
      READ  = 5'b10000
   } state_t;
endpackage

// File: rtl/sdram_aref_timer.sv
// sdram_aref_timer: refresh interval counter raising a pending-refresh flag and a sticky miss flag.
module sdram_aref_timer import sdram_pkg::*; #(
   parameter int CNT_REF = CNT_REF_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic init_end,
   input  logic aref_ack,
   output logic aref_pend,
   output logic aref_miss
);
   localparam int CW = $clog2(CNT_REF);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d, miss_q, miss_d, wrap;
   always_comb begin
      wrap   = init_end && cnt_q == CW'(CNT_REF - 1);
      cnt_d  = !init_end ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
      // a new interval expiring outranks the acknowledge of the previous one
      pend_d = wrap | (pend_q & ~aref_ack);
      miss_d = miss_q | (wrap & pend_q);
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
         miss_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         miss_q <= miss_d;
      end
   assign aref_pend = pend_q;
   assign aref_miss = miss_q;
endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter; refresh first, then write/read round-robin,
// muxing the granted requester onto the SDRAM pins.
module sdram_arbit import sdram_pkg::*; #(
   parameter int CNT_REF = CNT_REF_DEF,
   parameter int BA_W    = 2,
   parameter int ADDR_W  = 13
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [3:0]        aref_cmd,
   input  logic [BA_W-1:0]   aref_ba,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              aref_end,
   input  logic              wr_req,
   input  logic [3:0]        wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_end,
   input  logic              wr_sdram_en,
   input  logic [15:0]       wr_sdram_data,
   input  logic              rd_req,
   input  logic [3:0]        rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_end,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic              aref_miss,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   inout  wire  [15:0]       sdram_dq
);
   state_t state_q;
   logic   last_wr_q, aref_pend, aref_ack;
   logic [3:0] cmd;
   assign aref_ack = state_q == ARBIT && aref_pend;
   sdram_aref_timer #(.CNT_REF(CNT_REF)) u_timer (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .init_end  (init_end),
      .aref_ack  (aref_ack),
      .aref_pend (aref_pend),
      .aref_miss (aref_miss)
   );
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
      end else
         case (state_q)
            IDLE:  if (init_end) state_q <= ARBIT;
            ARBIT:
               if (aref_pend) state_q <= AREF;
               else if (wr_req && (!rd_req || !last_wr_q)) begin
                  state_q   <= WRITE;
                  last_wr_q <= 1'b1;
               end else if (rd_req) begin
                  state_q   <= READ;
                  last_wr_q <= 1'b0;
               end
            AREF:  if (aref_end) state_q <= ARBIT;
            WRITE: if (wr_end) state_q <= ARBIT;
            READ:  if (rd_end) state_q <= ARBIT;
            default: state_q <= IDLE;
         endcase
   assign aref_en   = state_q == AREF;
   assign wr_en     = state_q == WRITE;
   assign rd_en     = state_q == READ;
   assign sdram_cke = 1'b1;
   always_comb
      {cmd, sdram_ba, sdram_addr} =
         state_q == AREF  ? {aref_cmd, aref_ba, aref_addr} :
         state_q == WRITE ? {wr_cmd, wr_ba, wr_addr} :
         state_q == READ  ? {rd_cmd, rd_ba, rd_addr} :
         state_q == ARBIT ? {CMD_NOP, {BA_W{1'b1}}, {ADDR_W{1'b1}}} :
                            {init_cmd, init_ba, init_addr};
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
   assign sdram_dq = (state_q == WRITE && wr_sdram_en) ? wr_sdram_data : 16'hzzzz;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: randomized scenarios against a behavioural arbiter model kept in the bench.
module tb_sdram_arbit;
   localparam int CNT_REF = 750;
   logic sys_clk = 1'b0, sys_rst_n = 1'b1, init_end = 1'b0;
   logic [3:0] init_cmd, aref_cmd, wr_cmd, rd_cmd;
   logic [1:0] init_ba, aref_ba, wr_ba, rd_ba;
   logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
   logic aref_end = 1'b0, wr_req = 1'b0, wr_end = 1'b0, wr_sdram_en = 1'b0;
   logic rd_req = 1'b0, rd_end = 1'b0;
   logic [15:0] wr_sdram_data = 16'h1;
   logic aref_en, wr_en, rd_en, aref_miss, sdram_cke;
   logic sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0] sdram_ba;
   logic [12:0] sdram_addr;
   wire [15:0] sdram_dq;
   int n_pass = 0, n_chk = 0;
   // model: m_st 0=idle 1=arbitrate 2=refresh 3=write 4=read; m_tick = cycles counted with init_end high
   int m_st = 0, m_tick = 0;
   bit m_pend = 0, m_miss = 0, m_last_wr = 0, m_wrapped = 0;

   sdram_arbit #(.CNT_REF(CNT_REF), .BA_W(2), .ADDR_W(13)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr), .aref_end(aref_end),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_end(wr_end),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .aref_miss(aref_miss),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
      .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
   );

   always #5 sys_clk = ~sys_clk;
   // the bench holds the bus at zero whenever the arbiter must leave it floating
   assign sdram_dq = (m_st == 3 && wr_sdram_en) ? 16'hzzzz : 16'h0000;

   function automatic void model_reset();
      m_st = 0; m_tick = 0; m_pend = 0; m_miss = 0; m_last_wr = 0; m_wrapped = 0;
   endfunction

   function automatic void model_step();
      int nst = m_st;
      bit take = 0;
      m_wrapped = init_end && (m_tick % CNT_REF) == CNT_REF - 1;
      if (m_st == 0 && init_end) nst = 1;
      else if (m_st == 1) begin
         if (m_pend) begin nst = 2; take = 1; end
         else if (wr_req && rd_req) nst = m_last_wr ? 4 : 3;
         else if (wr_req) nst = 3;
         else if (rd_req) nst = 4;
      end else if ((m_st == 2 && aref_end) || (m_st == 3 && wr_end) || (m_st == 4 && rd_end)) nst = 1;
      if (nst == 3 && m_st == 1) m_last_wr = 1;
      if (nst == 4 && m_st == 1) m_last_wr = 0;
      if (m_wrapped && m_pend) m_miss = 1;
      m_pend = m_wrapped || (m_pend && !take);
      if (init_end) m_tick++;
      m_st = nst;
   endfunction

   function automatic logic [18:0] exp_bus();
      case (m_st)
         1: return {4'b0111, 2'b11, 13'h1fff};
         2: return {aref_cmd, aref_ba, aref_addr};
         3: return {wr_cmd, wr_ba, wr_addr};
         4: return {rd_cmd, rd_ba, rd_addr};
         default: return {init_cmd, init_ba, init_addr};
      endcase
   endfunction

   function automatic logic [39:0] exp_vec();
      return {m_st == 2, m_st == 3, m_st == 4, m_miss, 1'b1, exp_bus(),
              (m_st == 3 && wr_sdram_en) ? wr_sdram_data : 16'h0000};
   endfunction

   function automatic logic [39:0] obs_vec();
      return {aref_en, wr_en, rd_en, aref_miss, sdram_cke, sdram_cs_n, sdram_ras_n,
              sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr, sdram_dq};
   endfunction

   task automatic rand_bus();
      init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_ba = 2'($urandom); aref_ba = 2'($urandom); wr_ba = 2'($urandom); rd_ba = 2'($urandom);
      init_addr = 13'($urandom); aref_addr = 13'($urandom); wr_addr = 13'($urandom); rd_addr = 13'($urandom);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rand_bus();
      init_cmd = 4'b0010;
      #2 sys_rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL reset_state obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      repeat (5) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL idle_hold obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
      end
      n_chk++; if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== 4'b0010)
         $display("FAIL init_passthru cmd=%b want=0010", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}); else n_pass++;
      init_end = 1'b1;
      tick();
      n_chk++; if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== 4'b0111)
         $display("FAIL arbit_nop cmd=%b want=0111", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}); else n_pass++;
   endtask

   task automatic test_write();
      int cnt = 0;
      wr_req = 1'b1;
      wr_sdram_en = 1'b1;
      wr_sdram_data = 16'($urandom) | 16'h1;
      for (int t = 0; t < 5 && m_st != 3; t++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL write_req obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
      end
      n_chk++; if (wr_en !== 1'b1) $display("FAIL write_grant wr_en=%b want=1", wr_en); else n_pass++;
      cnt = 1;
      for (int i = 1; i <= 24; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL write_burst obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
         if (wr_en) cnt++;
         wr_end = (i == 20);
         if (i == 20) wr_req = 1'b0;
         wr_sdram_en = 1'($urandom);
         wr_sdram_data = 16'($urandom) | 16'h1;
         rand_bus();
      end
      wr_sdram_en = 1'b0;
      n_chk++; if (cnt != 21) $display("FAIL write_len cycles=%0d want=21", cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int len = 0, nop = 1, last = -1, prev = 0, grants = 0, g;
      wr_req = 1'b1;
      rd_req = 1'b1;
      for (int i = 0; i < 85; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL rr_cycle obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
         g = wr_en ? 3 : rd_en ? 4 : 0;
         if (g != 0 && g != prev) begin
            grants++;
            if (last != -1) begin
               n_chk++; if (nop != 1) $display("FAIL rr_gap nop=%0d want=1", nop); else n_pass++;
               n_chk++; if (g == last) $display("FAIL rr_alternate grant=%0d repeated", g); else n_pass++;
            end
            last = g;
         end
         nop = (g == 0) ? nop + 1 : 0;
         prev = g;
         len = (m_st == 3 || m_st == 4) ? len + 1 : 0;
         wr_end = m_st == 3 && len == 10;
         rd_end = m_st == 4 && len == 10;
         if (i == 70) begin wr_req = 1'b0; rd_req = 1'b0; end
         rand_bus();
      end
      wr_end = 1'b0;
      rd_end = 1'b0;
      n_chk++; if (grants != 7) $display("FAIL rr_count grants=%0d want=7", grants); else n_pass++;
   endtask

   task automatic test_refresh();
      int wrap_at = -1, rise_at = -1, n_aref = 0, len = 0;
      bit prev = 0;
      for (int i = 0; i < CNT_REF + 60; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL aref_cycle obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
         if (m_wrapped && wrap_at < 0) wrap_at = i;
         if (aref_en && !prev && rise_at < 0) rise_at = i;
         if (!aref_en && prev) begin
            n_chk++; if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== 4'b0111)
               $display("FAIL aref_return cmd=%b want=0111", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}); else n_pass++;
         end
         if (aref_en) n_aref++;
         prev = aref_en;
         len = (m_st == 2) ? len + 1 : 0;
         aref_end = m_st == 2 && len == 8;
         rand_bus();
      end
      aref_end = 1'b0;
      n_chk++; if (wrap_at < 0 || rise_at - wrap_at != 1)
         $display("FAIL aref_latency wrap=%0d rise=%0d want rise=wrap+1", wrap_at, rise_at); else n_pass++;
      n_chk++; if (n_aref != 8) $display("FAIL aref_len cycles=%0d want=8", n_aref); else n_pass++;
   endtask

   task automatic test_defer();
      int len = 0, prev = 0, g;
      int seq[$];
      for (int i = 0; i < CNT_REF + 10 && (m_tick % CNT_REF) != 699; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL defer_wait obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
      end
      wr_req = 1'b1;
      for (int i = 0; i < 160; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL defer_cycle obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
         g = aref_en ? 2 : wr_en ? 3 : rd_en ? 4 : 0;
         if (g != 0 && g != prev) seq.push_back(g);
         prev = g;
         if (m_st == 3) rd_req = 1'b1;
         len = (m_st >= 2) ? len + 1 : 0;
         wr_end = m_st == 3 && len == 100;
         aref_end = m_st == 2 && len == 8;
         rd_end = m_st == 4 && len == 10;
         if (wr_end) wr_req = 1'b0;
         if (rd_end) rd_req = 1'b0;
         rand_bus();
      end
      wr_end = 1'b0; aref_end = 1'b0; rd_end = 1'b0;
      n_chk++; if (seq.size() != 3 || seq[0] != 3 || seq[1] != 2 || seq[2] != 4)
         $display("FAIL defer_order n=%0d first=%0d second=%0d third=%0d want 3,2,4",
                  seq.size(), seq[0], seq[1], seq[2]); else n_pass++;
      n_chk++; if (aref_miss !== 1'b0) $display("FAIL defer_miss aref_miss=%b want=0", aref_miss); else n_pass++;
   endtask

   task automatic test_miss_reset();
      int len = 0;
      wr_req = 1'b1;
      wr_sdram_en = 1'b1;
      wr_sdram_data = 16'($urandom) | 16'h1;
      for (int i = 0; i < 2 * CNT_REF + 100; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL miss_cycle obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
         len = (m_st == 2) ? len + 1 : 0;
         aref_end = m_st == 2 && len == 8;
      end
      aref_end = 1'b0;
      n_chk++; if (aref_miss !== 1'b1 || wr_en !== 1'b1)
         $display("FAIL miss_set aref_miss=%b wr_en=%b want 1,1", aref_miss, wr_en); else n_pass++;
      @(posedge sys_clk);
      #3 sys_rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++; if (wr_en !== 1'b0 || aref_miss !== 1'b0)
         $display("FAIL async_reset wr_en=%b aref_miss=%b want 0,0", wr_en, aref_miss); else n_pass++;
      n_chk++; if (sdram_dq !== 16'h0000) $display("FAIL reset_dq dq=%h want released", sdram_dq); else n_pass++;
      n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL reset_vec obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      wr_req = 1'b0;
      wr_sdram_en = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 900; i++) begin
         tick();
         n_chk++; if (obs_vec() !== exp_vec()) $display("FAIL random_cycle obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
         wr_req = $urandom_range(0, 2) != 0;
         rd_req = $urandom_range(0, 2) != 0;
         wr_end = $urandom_range(0, 5) == 0;
         rd_end = $urandom_range(0, 5) == 0;
         aref_end = $urandom_range(0, 3) == 0;
         init_end = $urandom_range(0, 7) != 0;
         wr_sdram_en = 1'($urandom);
         wr_sdram_data = 16'($urandom) | 16'h1;
         rand_bus();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_refresh();
      test_defer();
      test_miss_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
